pclk_step_driver: RTL and testbench



---
 rtl/pclk_pkg.sv | 23 ++
 rtl/pclk_step_driver_if.sv | 19 +
 rtl/pclk_phase_lane.sv | 62 ++++++
 rtl/pclk_step_driver.sv | 103 ++++++++++
 tb/tb_pclk_step_driver.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pclk_pkg.sv
// Shared types and helpers for the stepwise adiabatic power-clock driver; pure
// elaboration-time functions, no latency, no backpressure.
package pclk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int calc_lw(input int nstep);
        return $clog2(nstep + 1);
    endfunction

    // Trapezoid: ramp up, hold at vdd, ramp down, rest at vss.
    function automatic int level_of(input int s, input int nstep);
        if (s < nstep)          return s + 1;
        else if (s < 2 * nstep) return nstep;
        else if (s < 3 * nstep) return 3 * nstep - 1 - s;
        else                    return 0;
    endfunction

endpackage

// File: rtl/pclk_step_driver_if.sv
// Run request in, per-phase level/select rails out; outputs registered, en is
// a level request with no backpressure.
interface pclk_step_driver_if
    import pclk_pkg::*;
#(
    parameter int NPHASE = 4,
    parameter int NSTEP  = 4
);
    localparam int LW = calc_lw(NSTEP);

    logic                          en;
    logic                          busy;
    logic                          frame_tick;
    logic [NPHASE*LW-1:0]          level;
    logic [NPHASE*(NSTEP+1)-1:0]   sel;

    modport master (input en, output busy, frame_tick, level, sel);
    modport slave  (output en, input busy, frame_tick, level, sel);
endinterface

// File: rtl/pclk_phase_lane.sv
// One power-clock phase: active flag, level register and one-hot switch select;
// 1-cycle registered outputs from next-state timebase, no backpressure.
module pclk_phase_lane
    import pclk_pkg::*;
#(
    parameter  int NSTEP = 4,
    localparam int P     = 4 * NSTEP,
    localparam int LW    = calc_lw(NSTEP),
    localparam int SW    = $clog2(P)
)(
    input  logic           clk,
    input  logic           rst,
    input  state_t         state_i,
    input  logic [SW-1:0]  slot_i,
    input  logic [SW-1:0]  offset_i,
    output logic           active_o,
    output logic [LW-1:0]  level_o,
    output logic [NSTEP:0] sel_o
);

    logic [SW-1:0]  s_loc;
    logic           active_d, active_q;
    logic [LW-1:0]  level_d, level_q;
    logic [NSTEP:0] onehot;
    logic [NSTEP:0] sel_d, sel_q;

    always_comb begin
        s_loc = (slot_i >= offset_i) ? (slot_i - offset_i)
                                     : (slot_i + SW'(P) - offset_i);
        active_d = active_q;
        if (state_i == RUN && s_loc == '0) begin
            active_d = 1'b1;
        end else if (state_i == DRAIN && int'(s_loc) == 3 * NSTEP) begin
            active_d = 1'b0;
        end
        level_d = active_d ? LW'(level_of(int'(s_loc), NSTEP)) : '0;
        onehot  = (NSTEP + 1)'(1) << level_d;
`ifdef PCLK_DEADTIME_EN
        // Open every switch for the first cycle after a level change.
        sel_d = (level_d != level_q) ? '0 : onehot;
`else
        sel_d = onehot;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            level_q  <= '0;
            sel_q    <= (NSTEP + 1)'(1);
        end else begin
            active_q <= active_d;
            level_q  <= level_d;
            sel_q    <= sel_d;
        end
    end

    assign active_o = active_q;
    assign level_o  = level_q;
    assign sel_o    = sel_q;

endmodule

// File: rtl/pclk_step_driver.sv
// NPHASE staggered stepwise power-clock controller; outputs registered (1 cycle), en is a
// level request without backpressure. Optional break-before-make gap: PCLK_DEADTIME_EN.
module pclk_step_driver
    import pclk_pkg::*;
#(
    parameter int NPHASE   = 4,
    parameter int NSTEP    = 4,
    parameter int STEP_CYC = 2
)(
    input logic                clk,
    input logic                rst,
    pclk_step_driver_if.master bus
);

    localparam int P         = 4 * NSTEP;
    localparam int LW        = calc_lw(NSTEP);
    localparam int SW        = $clog2(P);
    localparam int CW        = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int LANE_SPAN = P / NPHASE;
    localparam logic [CW-1:0] CYC_LAST  = CW'(STEP_CYC - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(P - 1);

    if ((4 * NSTEP) % NPHASE != 0) begin : g_err_nphase
        $error("NPHASE must divide 4*NSTEP");
    end
    if (NSTEP < 1) begin : g_err_nstep
        $error("NSTEP must be at least 1");
    end
    if (STEP_CYC < 1) begin : g_err_stepcyc
        $error("STEP_CYC must be at least 1");
    end
`ifdef PCLK_DEADTIME_EN
    if (STEP_CYC < 2) begin : g_err_deadtime
        $error("dead-time gap needs STEP_CYC >= 2");
    end
`endif

    state_t        state_d, state_q;
    logic [CW-1:0] cyc_d, cyc_q;
    logic [SW-1:0] slot_d, slot_q;
    logic          busy_q, frame_tick_q;
    logic [NPHASE-1:0]          active_w;
    logic [NPHASE*LW-1:0]       level_w;
    logic [NPHASE*(NSTEP+1)-1:0] sel_w;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE:    if (bus.en)          state_d = RUN;
            RUN:     if (!bus.en)         state_d = DRAIN;
            DRAIN:   if (active_w == '0)  state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
        // Counters sit at zero in IDLE so the entry edge starts at slot 0, cycle 0.
        if (state_q == IDLE || state_d == IDLE) begin
            cyc_d  = '0;
            slot_d = '0;
        end else if (cyc_q == CYC_LAST) begin
            cyc_d  = '0;
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end else begin
            cyc_d  = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            slot_q       <= '0;
            busy_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            slot_q       <= slot_d;
            busy_q       <= (state_d != IDLE);
            frame_tick_q <= (state_d == RUN) && (slot_d == '0) && (cyc_d == '0);
        end
    end

    // Lanes see next-state timebase so their registers line up with ours.
    for (genvar k = 0; k < NPHASE; k++) begin : g_lane
        pclk_phase_lane #(.NSTEP(NSTEP)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .state_i  (state_d),
            .slot_i   (slot_d),
            .offset_i (SW'(k * LANE_SPAN)),
            .active_o (active_w[k]),
            .level_o  (level_w[k*LW +: LW]),
            .sel_o    (sel_w[k*(NSTEP+1) +: NSTEP+1])
        );
    end

    assign bus.busy       = busy_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.level      = level_w;
    assign bus.sel        = sel_w;

endmodule

// File: tb/tb_pclk_step_driver.sv
// Directed vector table plus randomized run/drain/reset traffic against a time-indexed model.
module tb_pclk_step_driver;

    localparam int NPH  = 4;
    localparam int NS   = 4;
    localparam int SC   = 2;
    localparam int P    = 4 * NS;
    localparam int LW   = 3;
    localparam int SELW = NS + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pclk_step_driver_if #(.NPHASE(NPH), .NSTEP(NS)) bus ();

    pclk_step_driver #(.NPHASE(NPH), .NSTEP(NS), .STEP_CYC(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          r;
        bit          e;
        int          n;
        bit          busy;
        bit          ft;
        logic [11:0] lvl;
        logic [19:0] sel;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit e, input int n, input bit b,
                                input bit ft, input logic [11:0] l, input logic [19:0] s);
        vec_t v;
        v.r = r; v.e = e; v.n = n; v.busy = b; v.ft = ft; v.lvl = l; v.sel = s;
        return v;
    endfunction

    // Reference model: elapsed cycles since RUN entry, slot derived arithmetically.
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
    int m_st, m_t;
    bit m_act [NPH];
    int m_lvl [NPH];
    int m_prev[NPH];

    function automatic int prof(input int s);
        if (s < NS)     return s + 1;
        if (s < 2 * NS) return NS;
        if (s < 3 * NS) return 3 * NS - 1 - s;
        return 0;
    endfunction

    function automatic void model_step(input bit r, input bit e);
        bit any;
        int slot, s;
        if (r) begin
            m_st = M_IDLE; m_t = 0;
            for (int k = 0; k < NPH; k++) begin
                m_act[k] = 1'b0; m_lvl[k] = 0; m_prev[k] = 0;
            end
            return;
        end
        any = 1'b0;
        for (int k = 0; k < NPH; k++) any |= m_act[k];
        case (m_st)
            M_IDLE:  if (e) begin m_st = M_RUN; m_t = 0; end
            M_RUN:   begin m_t++; if (!e) m_st = M_DRAIN; end
            default: if (!any) begin m_st = M_IDLE; m_t = 0; end else m_t++;
        endcase
        slot = (m_t / SC) % P;
        for (int k = 0; k < NPH; k++) begin
            s = (slot - k * (P / NPH) + P) % P;
            if (m_st == M_RUN && s == 0)             m_act[k] = 1'b1;
            else if (m_st == M_DRAIN && s == 3 * NS) m_act[k] = 1'b0;
            m_prev[k] = m_lvl[k];
            m_lvl[k]  = m_act[k] ? prof(s) : 0;
        end
    endfunction

    function automatic logic [19:0] exp_sel();
        logic [19:0] v = '0;
        logic [4:0]  one;
        for (int k = 0; k < NPH; k++) begin
            one = 5'd1 << m_lvl[k];
`ifdef PCLK_DEADTIME_EN
            if (m_lvl[k] != m_prev[k]) one = '0;
`endif
            v[k*SELW +: SELW] = one;
        end
        return v;
    endfunction

    function automatic logic [11:0] exp_lvl();
        logic [11:0] v = '0;
        for (int k = 0; k < NPH; k++) v[k*LW +: LW] = 3'(m_lvl[k]);
        return v;
    endfunction

    vec_t tbl[20];
    int   dut_prev[NPH];

    initial begin
        bit en_v;
        int hold;
        int maxd, cur;
        bit rst_prev;

        tbl[0]  = mk(1, 1,  3, 0, 0, 12'h000, 20'h08421);
        tbl[1]  = mk(0, 1,  1, 1, 1, 12'h001, 20'h08422);
        tbl[2]  = mk(0, 1,  1, 1, 0, 12'h001, 20'h08422);
        tbl[3]  = mk(0, 1,  1, 1, 0, 12'h002, 20'h08424);
        tbl[4]  = mk(0, 1,  5, 1, 0, 12'h004, 20'h08430);
        tbl[5]  = mk(0, 1,  1, 1, 0, 12'h00C, 20'h08450);
        tbl[6]  = mk(0, 1,  8, 1, 0, 12'h063, 20'h08A08);
        tbl[7]  = mk(0, 1,  8, 1, 0, 12'h318, 20'h14101);
        tbl[8]  = mk(0, 1,  8, 1, 1, 12'h8C1, 20'h82022);
        tbl[9]  = mk(0, 1,  1, 1, 0, 12'h8C1, 20'h82022);
        tbl[10] = mk(0, 1, 11, 1, 0, 12'h21C, 20'h10510);
        tbl[11] = mk(0, 0,  1, 1, 0, 12'h21C, 20'h10510);
        tbl[12] = mk(0, 0, 15, 1, 0, 12'h108, 20'h0C041);
        tbl[13] = mk(0, 0, 12, 1, 0, 12'h000, 20'h08421);
        tbl[14] = mk(0, 0,  1, 0, 0, 12'h000, 20'h08421);
        tbl[15] = mk(0, 0,  3, 0, 0, 12'h000, 20'h08421);
        tbl[16] = mk(0, 1,  1, 1, 1, 12'h001, 20'h08422);
        tbl[17] = mk(0, 1, 10, 1, 0, 12'h014, 20'h08490);
        tbl[18] = mk(1, 1,  1, 0, 0, 12'h000, 20'h08421);
        tbl[19] = mk(0, 1,  1, 1, 1, 12'h001, 20'h08422);

        for (int i = 0; i < 20; i++) begin
            rst    = tbl[i].r;
            bus.en = tbl[i].e;
            repeat (tbl[i].n) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_busy", i),  32'(bus.busy),       32'(tbl[i].busy));
            check($sformatf("vec%0d_ftick", i), 32'(bus.frame_tick), 32'(tbl[i].ft));
            check($sformatf("vec%0d_level", i), 32'(bus.level),      32'(tbl[i].lvl));
`ifndef PCLK_DEADTIME_EN
            check($sformatf("vec%0d_sel", i),   32'(bus.sel),        32'(tbl[i].sel));
`endif
        end

        rst = 1'b1; bus.en = 1'b0;
        @(posedge clk); model_step(1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < NPH; k++) dut_prev[k] = 0;
        rst_prev = 1'b1;
        hold = 0; en_v = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                en_v = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 90);
            end
            hold--;
            rst    = ($urandom_range(0, 299) == 0);
            bus.en = en_v;
            @(posedge clk);
            model_step(rst, en_v);
            @(negedge clk);
            check("rnd_busy",  32'(bus.busy),       32'(m_st != M_IDLE));
            check("rnd_ftick", 32'(bus.frame_tick), 32'(m_st == M_RUN && (m_t % (SC * P)) == 0));
            check("rnd_level", 32'(bus.level),      32'(exp_lvl()));
            check("rnd_sel",   32'(bus.sel),        32'(exp_sel()));
            maxd = 0;
            for (int k = 0; k < NPH; k++) begin
                cur = int'(bus.level[k*LW +: LW]);
                if (!rst && !rst_prev) begin
                    if (cur - dut_prev[k] > maxd) maxd = cur - dut_prev[k];
                    if (dut_prev[k] - cur > maxd) maxd = dut_prev[k] - cur;
                end
                dut_prev[k] = cur;
            end
            check("rnd_step_le1", 32'(maxd <= 1), 32'd1);
            rst_prev = rst;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
